// File: rtl/controlador_entrada.sv
// Keypad entry sequencer: debounces held keys, accumulates BCD digits and converts to binary on enter.
// Optional backspace on key 0xC when BACKSPACE_EN is defined.
module controlador_entrada #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned BIN_W          = 14,
  parameter int unsigned RELEASE_CYCLES = 8192
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  output logic [4*NUM_DIGITS-1:0]            bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
  output logic [BIN_W-1:0]                   value,
  output logic                               value_valid,
  input  logic                               value_ready,
  output logic                               busy,
  output logic                               overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned REL_W = $clog2(RELEASE_CYCLES + 1);

  localparam logic [3:0] KEY_BACK  = 4'hC;
  localparam logic [3:0] KEY_CLEAR = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_CONVERT,
    ST_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [CNT_W-1:0]   count_d;
  logic [BIN_W-1:0]   value_d;
  logic               value_valid_d;
  logic               busy_d;
  logic               overflow_d;
  logic               released_q, released_d;
  logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               accept;
  logic [3:0]         cur_digit;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ENTRY;
      bcd         <= '0;
      digit_count <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      released_q  <= 1'b1;
      rel_cnt_q   <= '0;
      acc_q       <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      bcd         <= bcd_d;
      digit_count <= count_d;
      value       <= value_d;
      value_valid <= value_valid_d;
      busy        <= busy_d;
      overflow    <= overflow_d;
      released_q  <= released_d;
      rel_cnt_q   <= rel_cnt_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
    end
  end

  // Digit under conversion, most significant first as step advances
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (step_q == CNT_W'(int'(NUM_DIGITS) - 1 - i)) cur_digit = bcd[4*i +: 4];
    end
  end

  assign accept = key_valid && released_q;

  // Next-state, release filter and entry/convert datapath
  always_comb begin
    state_d       = state_q;
    bcd_d         = bcd;
    count_d       = digit_count;
    value_d       = value;
    value_valid_d = value_valid;
    overflow_d    = 1'b0;
    released_d    = released_q;
    rel_cnt_d     = rel_cnt_q;
    acc_d         = acc_q;
    step_d        = step_q;

    // Held keys repeat faster than RELEASE_CYCLES, so only the first event of a hold passes
    if (key_valid) begin
      released_d = 1'b0;
      rel_cnt_d  = '0;
    end else begin
      if (rel_cnt_q != REL_W'(RELEASE_CYCLES)) rel_cnt_d = rel_cnt_q + REL_W'(1);
      if (rel_cnt_d == REL_W'(RELEASE_CYCLES)) released_d = 1'b1;
    end

    unique case (state_q)
      ST_ENTRY: begin
        if (accept) begin
          if (key_code <= 4'd9) begin
            if (digit_count < CNT_W'(NUM_DIGITS)) begin
              bcd_d   = {bcd[BCD_W-5:0], key_code};
              count_d = digit_count + CNT_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else if (key_code == KEY_CLEAR) begin
            bcd_d   = '0;
            count_d = '0;
          end else if (key_code == KEY_ENTER) begin
            if (digit_count != '0) begin
              acc_d   = '0;
              step_d  = '0;
              state_d = ST_CONVERT;
            end
`ifdef BACKSPACE_EN
          end else if (key_code == KEY_BACK) begin
            if (digit_count != '0) begin
              bcd_d   = {4'd0, bcd[BCD_W-1:4]};
              count_d = digit_count - CNT_W'(1);
            end
`endif
          end
        end
      end

      ST_CONVERT: begin
        // One digit per cycle; the extra final step publishes the result
        if (step_q == CNT_W'(NUM_DIGITS)) begin
          value_d       = acc_q;
          value_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end else begin
          acc_d  = (acc_q << 3) + (acc_q << 1) + BIN_W'(cur_digit);
          step_d = step_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (value_valid && value_ready) begin
          value_valid_d = 1'b0;
          bcd_d         = '0;
          count_d       = '0;
          state_d       = ST_ENTRY;
        end
      end

      default: state_d = ST_ENTRY;
    endcase

    busy_d = (state_d == ST_CONVERT) || (state_d == ST_HOLD);
  end

endmodule

// File: tb/tb_controlador_entrada.sv
// Directed bench for controlador_entrada; release window shortened to keep run length small.
module tb_controlador_entrada;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BIN_W      = 14;
  localparam int unsigned REL        = 256;
  localparam int unsigned GAP        = REL + 8;
  localparam int unsigned HELD_GAP   = 170;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      key_valid;
  logic [3:0]                key_code;
  logic [4*NUM_DIGITS-1:0]   bcd;
  logic [2:0]                digit_count;
  logic [BIN_W-1:0]          value;
  logic                      value_valid;
  logic                      value_ready;
  logic                      busy;
  logic                      overflow;

  int checks = 0;
  int errors = 0;

  controlador_entrada #(
    .NUM_DIGITS    (NUM_DIGITS),
    .BIN_W         (BIN_W),
    .RELEASE_CYCLES(REL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .bcd        (bcd),
    .digit_count(digit_count),
    .value      (value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic gap();
    repeat (GAP) @(negedge clk);
  endtask

  task automatic handshake();
    @(negedge clk);
    value_ready = 1'b1;
    @(negedge clk);
    value_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    value_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_valid", 32'(value_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // 1: basic entry and conversion latency
    press(4'd1); gap(); press(4'd2); gap(); press(4'd3); gap();
    check("t1_bcd", 32'(bcd), 32'h0123);
    check("t1_count", 32'(digit_count), 32'd3);
    press(4'hE);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t1_valid_early", 32'(value_valid), 32'd0);
      @(negedge clk);
    end
    check("t1_valid_early", 32'(value_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(value_valid), 32'd1);
    check("t1_value", 32'(value), 32'd123);
    check("t1_hold_bcd", 32'(bcd), 32'h0123);
    handshake();
    check("t1_hs_valid", 32'(value_valid), 32'd0);
    check("t1_hs_bcd", 32'(bcd), 32'h0);
    check("t1_hs_count", 32'(digit_count), 32'd0);
    check("t1_hs_busy", 32'(busy), 32'd0);
    check("t1_hs_value", 32'(value), 32'd123);
    gap();

    // 2: held key repeats are filtered
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (HELD_GAP) @(negedge clk);
      press(4'd5);
    end
    check("t2_bcd", 32'(bcd), 32'h0005);
    check("t2_count", 32'(digit_count), 32'd1);
    repeat (REL - 40) @(negedge clk);
    press(4'd6);
    check("t2_early_bcd", 32'(bcd), 32'h0005);
    gap();
    press(4'd6);
    check("t2_late_bcd", 32'(bcd), 32'h0056);
    check("t2_late_count", 32'(digit_count), 32'd2);
    gap();
    press(4'hD);
    check("t2_clr_bcd", 32'(bcd), 32'h0);
    gap();

    // 3: overflow on fifth digit
    for (int d = 1; d <= 4; d++) begin
      press(4'(d));
      check("t3_no_ovf", 32'(overflow), 32'd0);
      gap();
    end
    press(4'd5);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_bcd", 32'(bcd), 32'h1234);
    check("t3_count", 32'(digit_count), 32'd4);
    @(negedge clk);
    check("t3_ovf_pulse", 32'(overflow), 32'd0);
    gap();
    press(4'hE);
    repeat (5) @(negedge clk);
    check("t3_valid", 32'(value_valid), 32'd1);
    check("t3_value", 32'(value), 32'd1234);
    handshake();
    gap();

    // 4: backpressure, presses during HOLD discarded
    press(4'd7); gap();
    press(4'hE);
    repeat (5) @(negedge clk);
    check("t4_valid", 32'(value_valid), 32'd1);
    check("t4_value", 32'(value), 32'd7);
    gap();
    press(4'd7);
    check("t4_hold_valid", 32'(value_valid), 32'd1);
    check("t4_hold_bcd", 32'(bcd), 32'h0007);
    check("t4_hold_count", 32'(digit_count), 32'd1);
    repeat (100) @(negedge clk);
    check("t4_hold_value", 32'(value), 32'd7);
    check("t4_hold_busy", 32'(busy), 32'd1);
    handshake();
    check("t4_hs_count", 32'(digit_count), 32'd0);
    check("t4_hs_valid", 32'(value_valid), 32'd0);
    press(4'd7);
    check("t4_consumed_bcd", 32'(bcd), 32'h0);
    gap();
    press(4'd7);
    check("t4_new_bcd", 32'(bcd), 32'h0007);
    check("t4_new_count", 32'(digit_count), 32'd1);
    gap();
    press(4'hD);
    gap();

    // 5: clear, empty enter, reset during conversion
    press(4'd9); gap(); press(4'd9); gap(); press(4'hD); gap();
    check("t5_clr_bcd", 32'(bcd), 32'h0);
    check("t5_clr_count", 32'(digit_count), 32'd0);
    press(4'hE);
    check("t5_empty_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("t5_empty_valid", 32'(value_valid), 32'd0);
    check("t5_empty_busy2", 32'(busy), 32'd0);
    gap();
    press(4'd4); gap(); press(4'd2); gap();
    press(4'hE);
    check("t5_conv_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_bcd", 32'(bcd), 32'h0);
    check("t5_rst_count", 32'(digit_count), 32'd0);
    check("t5_rst_value", 32'(value), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("t5_rst_valid", 32'(value_valid), 32'd0);
      @(negedge clk);
    end

    // 6: backspace key
    press(4'd4); gap(); press(4'd5); gap(); press(4'hC); gap(); press(4'd6); gap();
`ifdef BACKSPACE_EN
    check("t6_bcd", 32'(bcd), 32'h0046);
    check("t6_count", 32'(digit_count), 32'd2);
`else
    check("t6_bcd", 32'(bcd), 32'h0456);
    check("t6_count", 32'(digit_count), 32'd3);
`endif
    press(4'hE);
    repeat (5) @(negedge clk);
    check("t6_valid", 32'(value_valid), 32'd1);
`ifdef BACKSPACE_EN
    check("t6_value", 32'(value), 32'd46);
`else
    check("t6_value", 32'(value), 32'd456);
`endif
    handshake();
    check("t6_hs_valid", 32'(value_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
